bcd_addsub_serial: RTL and testbench

BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

---
 rtl/bcd_addsub_serial.sv | 186 ++++++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial
//
// Two-digit BCD adder/subtractor that processes one decimal digit per clock.
// An operation is accepted in IDLE. The ones digit is resolved in ONES and
// the tens digit, with the ones carry/borrow, in TENS. The result is then
// presented with a one-cycle done pulse in FINISH. If any captured operand
// digit is not a legal BCD digit, the arithmetic states are skipped and
// FINISH reports the operation as invalid.
//
// Ports
//   CLOCK_50            in   sole clock, rising-edge active
//   reset_n             in   asynchronous active-low reset
//   start               in   begin an operation (sampled only in IDLE)
//   operator            in   0 = A+B, 1 = A-B (captured with start)
//   a_bcd[7:0]          in   operand A, [7:4] tens digit, [3:0] ones digit
//   b_bcd[7:0]          in   operand B, same format as a_bcd
//   busy                out  high in every state except IDLE
//   done                out  high for the single FINISH cycle
//   result[7:0]         out  BCD result, [7:4] tens digit, [3:0] ones digit
//   overflow_underflow  out  carry (add) or borrow (subtract) out of tens
//   invalid             out  a captured operand digit was greater than 9
// ---------------------------------------------------------------------------
module bcd_addsub_serial (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       operator,
  input  logic [7:0] a_bcd,
  input  logic [7:0] b_bcd,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       overflow_underflow,
  output logic       invalid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ONES   = 2'd1,
    TENS   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_q, state_d;

  // Captured operation; frozen for the whole operation.
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       op_q, op_d;

  // Ones digit and its carry/borrow, held between ONES and TENS.
  logic [3:0] ones_q, ones_d;
  logic       cy_q, cy_d;

  // Visible result registers; written only on the edge that enters FINISH.
  logic [7:0] result_q, result_d;
  logic       ovf_q, ovf_d;
  logic       inv_q, inv_d;

  // {carry/borrow out, digit} for each digit position.
  logic [4:0] ones_res;
  logic [4:0] tens_res;
  logic       operands_ok;

  // One decimal digit of add or subtract with carry/borrow in.
  // The returned bit 4 is the carry/borrow out, and bits 3:0 are the
  // resulting BCD digit. For subtract, the 5-bit difference spans -10..9,
  // so bit 4 is the sign.
  function automatic logic [4:0] digit_step(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       cin,
                                            input logic       sub);
    logic [4:0] raw;
    logic [4:0] adj;
    if (!sub) begin
      raw = {1'b0, x} + {1'b0, y} + {4'd0, cin};
      if (raw > 5'd9) begin
        adj = raw - 5'd10;
        return {1'b1, adj[3:0]};
      end
      return {1'b0, raw[3:0]};
    end else begin
      raw = {1'b0, x} - {1'b0, y} - {4'd0, cin};
      if (raw[4]) begin
        adj = raw + 5'd10;
        return {1'b1, adj[3:0]};
      end
      return {1'b0, raw[3:0]};
    end
  endfunction

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  assign operands_ok = digit_ok(a_bcd[7:4]) && digit_ok(a_bcd[3:0]) &&
                       digit_ok(b_bcd[7:4]) && digit_ok(b_bcd[3:0]);

  assign ones_res = digit_step(a_q[3:0], b_q[3:0], 1'b0, op_q);
  assign tens_res = digit_step(a_q[7:4], b_q[7:4], cy_q, op_q);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ones_d   = ones_q;
    cy_d     = cy_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d  = a_bcd;
          b_d  = b_bcd;
          op_d = operator;
          if (operands_ok) begin
            state_d = ONES;
          end else begin
            // Bad operand: go straight to FINISH with the invalid result.
            state_d  = FINISH;
            result_d = 8'h00;
            ovf_d    = 1'b0;
            inv_d    = 1'b1;
          end
        end
      end

      ONES: begin
        ones_d  = ones_res[3:0];
        cy_d    = ones_res[4];
        state_d = TENS;
      end

      TENS: begin
        result_d = {tens_res[3:0], ones_q};
        ovf_d    = tens_res[4];
        inv_d    = 1'b0;
        state_d  = FINISH;
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 1'b0;
      ones_q   <= 4'h0;
      cy_q     <= 1'b0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ones_q   <= ones_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == FINISH);
  assign result             = result_q;
  assign overflow_underflow = ovf_q;
  assign invalid            = inv_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
module tb_bcd_addsub_serial;

  logic       CLOCK_50;
  logic       reset_n;
  logic       start;
  logic       operator;
  logic [7:0] a_bcd;
  logic [7:0] b_bcd;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow_underflow;
  logic       invalid;

  int n_pass;
  int n_total;

  bcd_addsub_serial dut (
    .CLOCK_50           (CLOCK_50),
    .reset_n            (reset_n),
    .start              (start),
    .operator           (operator),
    .a_bcd              (a_bcd),
    .b_bcd              (b_bcd),
    .busy               (busy),
    .done               (done),
    .result             (result),
    .overflow_underflow (overflow_underflow),
    .invalid            (invalid)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal reference: operands as integers 0..99, wrap/complement by 100.
  function automatic void ref_model(input logic [7:0] a, input logic [7:0] b,
                                    input logic op, output logic [7:0] r,
                                    output logic f, output logic inv);
    int av, bv, x;
    inv = (a[7:4] > 4'd9) || (a[3:0] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    r = 8'h00;
    f = 1'b0;
    if (!inv) begin
      av = int'(a[7:4]) * 10 + int'(a[3:0]);
      bv = int'(b[7:4]) * 10 + int'(b[3:0]);
      x  = op ? (av - bv) : (av + bv);
      if (x >= 100) begin x = x - 100; f = 1'b1; end
      if (x < 0)    begin x = x + 100; f = 1'b1; end
      r = {4'(x / 10), 4'(x % 10)};
    end
  endfunction

  // Drives one operation, scrambles the operand inputs right after capture,
  // and waits (bounded) for done. lat is the number of falling edges from
  // the accepting edge up to and including the first one that sees done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic op,
                        output int lat, output int bcnt, output logic [7:0] r,
                        output logic f, output logic inv,
                        output logic done_after, output logic [7:0] r_after);
    @(negedge CLOCK_50);
    a_bcd = a; b_bcd = b; operator = op; start = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
      if (busy) bcnt++;
      if (lat == 1) begin
        start = 1'b0;
        a_bcd = 8'($urandom);
        b_bcd = 8'($urandom);
        operator = ~op;
      end
    end while (!done && lat < 20);
    r = result; f = overflow_underflow; inv = invalid;
    @(negedge CLOCK_50);
    done_after = done;
    r_after = result;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b1; operator = 1'b0; a_bcd = 8'h25; b_bcd = 8'h37;
    repeat (3) @(negedge CLOCK_50);
    n_total++;
    if ({busy, done, result, overflow_underflow, invalid} !== 12'h000)
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h ovf=%b inv=%b, want all 0",
               busy, done, result, overflow_underflow, invalid);
    else n_pass++;
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_add;
    int lat, bcnt; logic [7:0] r, ra; logic f, inv, da;
    run_op(8'h25, 8'h37, 1'b0, lat, bcnt, r, f, inv, da, ra);
    n_total++;
    if (lat !== 3) $display("FAIL add_latency: got %0d want 3", lat); else n_pass++;
    n_total++;
    if (bcnt !== 3) $display("FAIL add_busy_cycles: got %0d want 3", bcnt); else n_pass++;
    n_total++;
    if ({r, f, inv} !== {8'h62, 1'b0, 1'b0})
      $display("FAIL add_result: got %h/%b/%b want 62/0/0", r, f, inv);
    else n_pass++;
    n_total++;
    if (da !== 1'b0) $display("FAIL add_done_one_cycle: done=%b want 0", da); else n_pass++;
    n_total++;
    if (ra !== 8'h62 || busy !== 1'b0)
      $display("FAIL add_hold: result=%h busy=%b want 62/0", ra, busy);
    else n_pass++;
  endtask

  task automatic test_carry_subtract;
    logic [7:0] ta [5] = '{8'h99, 8'h45, 8'h62, 8'h25, 8'h00};
    logic [7:0] tb [5] = '{8'h01, 8'h55, 8'h37, 8'h37, 8'h01};
    logic       to [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] tr [5] = '{8'h00, 8'h00, 8'h25, 8'h88, 8'h99};
    logic       tf [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat, bcnt; logic [7:0] r, ra; logic f, inv, da;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], to[i], lat, bcnt, r, f, inv, da, ra);
      n_total++;
      if ({r, f, inv} !== {tr[i], tf[i], 1'b0})
        $display("FAIL carry_sub_%0d: %h op%b %h got %h/%b/%b want %h/%b/0",
                 i, ta[i], to[i], tb[i], r, f, inv, tr[i], tf[i]);
      else n_pass++;
      n_total++;
      if (lat !== 3) $display("FAIL carry_sub_latency_%0d: got %0d want 3", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_invalid;
    int lat, bcnt; logic [7:0] r, ra; logic f, inv, da;
    run_op(8'h1A, 8'h00, 1'b0, lat, bcnt, r, f, inv, da, ra);
    n_total++;
    if (lat !== 1) $display("FAIL invalid_latency: got %0d want 1", lat); else n_pass++;
    n_total++;
    if ({r, f, inv} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL invalid_result: got %h/%b/%b want 00/0/1", r, f, inv);
    else n_pass++;
    n_total++;
    if (bcnt !== 1) $display("FAIL invalid_busy_cycles: got %0d want 1", bcnt); else n_pass++;
    run_op(8'h10, 8'h10, 1'b0, lat, bcnt, r, f, inv, da, ra);
    n_total++;
    if ({r, f, inv} !== {8'h20, 1'b0, 1'b0})
      $display("FAIL invalid_then_valid: got %h/%b/%b want 20/0/0", r, f, inv);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int pos[$];
    @(negedge CLOCK_50);
    a_bcd = 8'h11; b_bcd = 8'h11; operator = 1'b0; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLOCK_50);
      if (done) begin
        pos.push_back(n);
        n_total++;
        if (result !== 8'h22) $display("FAIL b2b_result: got %h want 22 at cycle %0d", result, n);
        else n_pass++;
      end
      if (n == 1) a_bcd = 8'h99;
      if (n == 3) a_bcd = 8'h11;
      if (n == 6) start = 1'b0;
    end
    n_total++;
    if (pos.size() !== 2) $display("FAIL b2b_pulse_count: got %0d want 2", pos.size());
    else n_pass++;
    if (pos.size() == 2) begin
      n_total++;
      if (pos[0] !== 3 || pos[1] - pos[0] !== 4)
        $display("FAIL b2b_spacing: got first=%0d gap=%0d want 3/4", pos[0], pos[1] - pos[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dcnt; logic [7:0] r, ra; logic f, inv, da;
    @(negedge CLOCK_50);
    a_bcd = 8'h25; b_bcd = 8'h37; operator = 1'b0; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
    n_total++;
    if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: busy=%b want 1", busy); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, result, overflow_underflow, invalid} !== 12'h000)
      $display("FAIL rst_mid_async: got busy=%b done=%b result=%h ovf=%b inv=%b, want all 0",
               busy, done, result, overflow_underflow, invalid);
    else n_pass++;
    dcnt = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (done || busy) dcnt++;
    end
    reset_n = 1'b1;
    n_total++;
    if (dcnt !== 0) $display("FAIL rst_mid_no_done: active cycles=%0d want 0", dcnt); else n_pass++;
    run_op(8'h50, 8'h20, 1'b1, lat, bcnt, r, f, inv, da, ra);
    n_total++;
    if ({r, f, inv} !== {8'h30, 1'b0, 1'b0} || lat !== 3)
      $display("FAIL rst_mid_after: got %h/%b/%b lat=%0d want 30/0/0 lat=3", r, f, inv, lat);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat, bcnt; logic [7:0] r, ra, a, b, er; logic f, inv, da, op, ef, einv;
    logic [3:0] d [4];
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 9) == 0) d[j] = 4'($urandom_range(10, 15));
        else d[j] = 4'($urandom_range(0, 9));
      end
      a = {d[0], d[1]}; b = {d[2], d[3]}; op = 1'($urandom_range(0, 1));
      ref_model(a, b, op, er, ef, einv);
      run_op(a, b, op, lat, bcnt, r, f, inv, da, ra);
      n_total++;
      if ({r, f, inv} !== {er, ef, einv})
        $display("FAIL random_%0d: %h op%b %h got %h/%b/%b want %h/%b/%b",
                 i, a, op, b, r, f, inv, er, ef, einv);
      else n_pass++;
      n_total++;
      if (lat !== (einv ? 1 : 3))
        $display("FAIL random_latency_%0d: got %0d want %0d", i, lat, einv ? 1 : 3);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; start = 1'b0; operator = 1'b0; a_bcd = 8'h00; b_bcd = 8'h00;
    test_reset;
    test_add;
    test_carry_subtract;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
